// File: rtl/sd_pkg.sv
// Shared SD data-path definitions: transmitter state encoding and CRC16 constants.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_DONE
  } sd_tx_state_e;

  localparam int               CRC_W      = 16;
  localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;  // x^16 + x^12 + x^5 + 1

  // One serial step of CRC16-CCITT: feedback is incoming bit xor current MSB.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic             bitval);
    logic fb;
    fb = bitval ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : {CRC_W{1'b0}});
  endfunction

endpackage

// File: rtl/sd_crc_16.sv
// Bit-serial CRC16-CCITT accumulator; RST is an active-high asynchronous clear.
module sd_crc_16
  import sd_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             BITVAL,
  input  logic             Enable,
  output logic [CRC_W-1:0] CRC
);

  logic [CRC_W-1:0] crc_q;

  // Fold one bit into the remainder on every enabled cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         crc_q <= '0;
    else if (Enable) crc_q <= crc16_step(crc_q, BITVAL);
  end

  assign CRC = crc_q;

endmodule

// File: rtl/sd_data_tx.sv
// SD DAT0 block transmitter: start bit, BLKSIZE bytes MSB first, CRC16, end bit.
// An empty upstream on a fetch cycle stalls the line and gates the card clock.
module sd_data_tx
  import sd_pkg::*;
#(
  parameter int BLKSIZE = 512
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       dat_out,
  output logic       dat_oe,
  output logic       clk_en,
  output logic       busy,
  output logic       done
);

  localparam logic [11:0] LAST_BYTE = 12'(BLKSIZE - 1);

  sd_tx_state_e     state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic [11:0]      byte_q, byte_d;
  logic [3:0]       crc_cnt_q, crc_cnt_d;
  logic [7:0]       sr_q, sr_d;
  logic [15:0]      crc_sr_q, crc_sr_d;
  logic             dat_out_q, dat_out_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic             stall_q, stall_d;
  logic             clr_q, clr_d;
  logic [CRC_W-1:0] crc_w, crc_final;
  logic             underrun;

  assign data_ready = (state_q == ST_START) ||
                      (state_q == ST_DATA && bit_q == 3'd0 && byte_q != LAST_BYTE);
  assign underrun   = data_ready && !data_valid;
  assign clk_en     = !stall_q;

  // The CRC sees the bit currently on the line, only on real (unstalled) data cycles.
  sd_crc_16 u_crc (
    .CLK    (CLK),
    .RST    (clr_q),
    .BITVAL (dat_out_q),
    .Enable ((state_q == ST_DATA) && clk_en),
    .CRC    (crc_w)
  );

  // Next state and next registered outputs; stalls freeze everything.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    crc_cnt_d = crc_cnt_q;
    sr_d      = sr_q;
    crc_sr_d  = crc_sr_q;
    dat_out_d = dat_out_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    stall_d   = 1'b0;
    clr_d     = 1'b0;
    // The accumulator lags by the bit on the line, so fold it in for the handoff.
    crc_final = crc16_step(crc_w, dat_out_q);
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      bit_d     = '0;
      byte_d    = '0;
      crc_cnt_d = '0;
      sr_d      = '0;
      crc_sr_d  = '0;
      dat_out_d = 1'b1;
      dat_oe_d  = 1'b0;
      clr_d     = 1'b1;
    end else if (underrun) begin
      stall_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d   = ST_START;
          bit_d     = '0;
          byte_d    = '0;
          dat_out_d = 1'b0;
          dat_oe_d  = 1'b1;
          clr_d     = 1'b1;
        end
        ST_START: begin
          state_d   = ST_DATA;
          bit_d     = 3'd7;
          dat_out_d = data_in[7];
          sr_d      = {data_in[6:0], 1'b0};
        end
        ST_DATA: begin
          if (bit_q != 3'd0) begin
            bit_d     = bit_q - 3'd1;
            dat_out_d = sr_q[7];
            sr_d      = {sr_q[6:0], 1'b0};
          end else if (byte_q == LAST_BYTE) begin
            state_d   = ST_CRC;
            crc_cnt_d = 4'd15;
            dat_out_d = crc_final[15];
            crc_sr_d  = {crc_final[14:0], 1'b0};
          end else begin
            byte_d    = byte_q + 12'd1;
            bit_d     = 3'd7;
            dat_out_d = data_in[7];
            sr_d      = {data_in[6:0], 1'b0};
          end
        end
        ST_CRC: begin
          if (crc_cnt_q == 4'd0) begin
            state_d   = ST_END;
            dat_out_d = 1'b1;
          end else begin
            crc_cnt_d = crc_cnt_q - 4'd1;
            dat_out_d = crc_sr_q[15];
            crc_sr_d  = {crc_sr_q[14:0], 1'b0};
          end
        end
        ST_END: begin
          state_d   = ST_DONE;
          dat_out_d = 1'b1;
          dat_oe_d  = 1'b0;
          done_d    = 1'b1;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers; the clear flop comes out of reset asserted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      byte_q    <= '0;
      crc_cnt_q <= '0;
      sr_q      <= '0;
      crc_sr_q  <= '0;
      dat_out_q <= 1'b1;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      stall_q   <= 1'b0;
      clr_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      crc_cnt_q <= crc_cnt_d;
      sr_q      <= sr_d;
      crc_sr_q  <= crc_sr_d;
      dat_out_q <= dat_out_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      busy_q    <= (state_d != ST_IDLE);
      stall_q   <= stall_d;
      clr_q     <= clr_d;
    end
  end

  assign dat_out = dat_out_q;
  assign dat_oe  = dat_oe_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: doc/sd_data_tx.md
SD_DATA_TX -- requirements
Module: sd_data_tx

Interface
REQ-001 Parameter BLKSIZE, default 512, shall set data bytes per block (legal range 1..2048).
REQ-002 CLK  input  1  shall be the single clock; all state changes on its rising edge.
REQ-003 RST  input  1  shall be the asynchronous, active-low reset.
REQ-004 start  input  1  shall request transmission of one block; sampled in IDLE only.
REQ-005 abort  input  1  shall request a synchronous abandon of the current block.
REQ-006 data_in  input  8  shall carry the next payload byte, transmitted MSB first.
REQ-007 data_valid  input  1  shall mark data_in valid.
REQ-008 data_ready  output  1  shall mark that a byte is accepted this cycle when data_valid is also high.
REQ-009 dat_out  output  1  shall be the serial DAT0 line value.
REQ-010 dat_oe  output  1  shall enable the DAT0 driver.
REQ-011 clk_en  output  1  shall be low during a stall cycle, so the card clock is gated.
REQ-012 busy  output  1  shall be high in every state except IDLE.
REQ-013 done  output  1  shall pulse for one cycle after the end bit.

Function
REQ-014 States IDLE, START, DATA, CRC, END, DONE; IDLE->START on start, START->DATA, DATA->CRC after bit 0 of byte BLKSIZE, CRC->END after 16 bits, END->DONE->IDLE.
REQ-015 IDLE: dat_out=1, dat_oe=0, clk_en=1, data_ready=0; start while busy shall be ignored.
REQ-016 START: dat_out=0 (start bit), dat_oe=1, data_ready=1 to fetch byte 0.
REQ-017 DATA: one bit per cycle from an 8-bit shift register, MSB first; 3-bit bit counter, 12-bit byte counter.
REQ-018 data_ready shall be high in START and on bit 0 of each byte except the last.
REQ-019 A byte shall be loaded into the shift register on a data_valid&data_ready cycle and first appear on dat_out the next cycle.
REQ-020 Underrun: if data_ready=1 and data_valid=0, the next cycle shall be a stall: clk_en=0, dat_out/dat_oe held, all counters and CRC frozen, data_ready held high until a handshake occurs.
REQ-021 CRC: CRC16-CCITT (x^16+x^12+x^5+1, init 0) over every transmitted data bit; advanced only on non-stall DATA cycles.
REQ-022 On DATA->CRC transition, the final CRC shall be loaded into a 16-bit shift register and sent MSB first, 16 cycles.
REQ-023 END: dat_out=1 (end bit), dat_oe=1; DONE: dat_oe=0, dat_out=1, done=1.
REQ-024 Latency: start sampled at cycle 0, start bit at cycle 1, first data bit at cycle 2 (no stall); total dat_oe-high cycles = 8*BLKSIZE+18 plus stall cycles.
REQ-025 abort in any non-IDLE state shall force IDLE next cycle with dat_oe=0, done=0, CRC cleared; abort has priority over all other transitions.
REQ-026 A simultaneous handshake and abort shall discard the byte.

Reset
REQ-027 RST low shall immediately force IDLE, dat_out=1, dat_oe=0, clk_en=1, data_ready=0, busy=0, done=0, counters and CRC=0, including mid-block.
REQ-028 After RST deasserts, a start shall be honoured on the first rising edge.

Structure
REQ-029 State encoding typedef and CRC polynomial/width constants shall live in shared package sd_pkg.
REQ-030 CRC shall be an instance of the team's sd_crc_16 unit, BITVAL=dat_out bit, Enable=DATA & clk_en, and RST driven by a registered clear flop pulsed high for one cycle in START and on abort.
REQ-031 All outputs except data_ready and clk_en shall be registered.

Verification
REQ-032 BLKSIZE=512, all bytes 0xFF, data_valid always high -> CRC bits 0x7FA1, 4114 dat_oe cycles, done one cycle after end bit.
REQ-033 BLKSIZE=1, byte 0x00 -> dat_out sequence 0, 0x00, CRC 0x0000, 1; done at cycle 27.
REQ-034 BLKSIZE=4, data_valid low 3 cycles before byte 2 -> exactly 3 clk_en=0 cycles, dat_out held, CRC identical to the unstalled run.
REQ-035 abort during CRC bit 5 -> dat_oe=0 next cycle, no done; a fresh start yields a correct block.
REQ-036 RST low during DATA byte 100 -> outputs at reset values asynchronously; start after release begins a clean block.
